// File: rtl/mult_pkg.sv
// Shared widths and the sign-magnitude word type for the multiplier datapath.
package mult_pkg;

  localparam int W      = 16;
  localparam int MAG_W  = W - 1;
  localparam int PROD_W = 2 * MAG_W;
  localparam logic [MAG_W-1:0] MAG_MAX = 15'h7FFF;

  typedef struct packed {
    logic             sign;
    logic [MAG_W-1:0] mag;
  } sm_word_t;

endpackage

// File: rtl/multiplier_umul15.sv
// Combinational unsigned 15x15 -> 30-bit multiplier.
// Uses a shift-add partial-product array and a balanced adder tree.
module umul15
  import mult_pkg::*;
(
  input  logic [MAG_W-1:0]  x,
  input  logic [MAG_W-1:0]  y,
  output logic [PROD_W-1:0] p
);

  // 15 real rows padded to 16 so the tree stays a clean 16-8-4-2-1 reduction
  logic [PROD_W-1:0] pp [16];
  logic [PROD_W-1:0] l1 [8];
  logic [PROD_W-1:0] l2 [4];
  logic [PROD_W-1:0] l3 [2];

  always_comb begin
    for (int i = 0; i < 16; i++) begin
      pp[i] = '0;
    end
    for (int i = 0; i < MAG_W; i++) begin
      pp[i] = y[i] ? ({{(PROD_W-MAG_W){1'b0}}, x} << i) : '0;
    end
    for (int i = 0; i < 8; i++) begin
      l1[i] = pp[2*i] + pp[2*i+1];
    end
    for (int i = 0; i < 4; i++) begin
      l2[i] = l1[2*i] + l1[2*i+1];
    end
    for (int i = 0; i < 2; i++) begin
      l3[i] = l2[2*i] + l2[2*i+1];
    end
    p = l3[0] + l3[1];
  end

endmodule

// File: rtl/multiplier.sv
// Two-stage pipelined 16-bit sign-magnitude multiplier with saturation.
// Stage 1 registers operands; stage 2 registers the saturated, zero-normalized product.
module multiplier
  import mult_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] c,
  output logic         ovf
);

  sm_word_t          a_q;
  sm_word_t          b_q;
  logic [PROD_W-1:0] prod;
  logic              sat;
  sm_word_t          res;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      a_q <= a;
      b_q <= b;
    end
  end

  umul15 u_umul15 (
    .x (a_q.mag),
    .y (b_q.mag),
    .p (prod)
  );

  // sign is dropped for a zero magnitude so 8000h never leaves the block
  always_comb begin
    sat      = |prod[PROD_W-1:MAG_W];
    res.mag  = sat ? MAG_MAX : prod[MAG_W-1:0];
    res.sign = (a_q.sign ^ b_q.sign) & (|res.mag);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      c   <= '0;
      ovf <= 1'b0;
    end else begin
      c   <= res;
      ovf <= sat;
    end
  end

endmodule

// File: tb/tb_multiplier.sv
// Self-checking bench for multiplier: directed vectors, pipeline stream, reset, random.
module tb_multiplier;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] a, b, c;
  logic        ovf;

  int total = 0;
  int bad   = 0;

  logic [15:0] va[$];
  logic [15:0] vb[$];
  logic [15:0] vc[$];
  logic        vo[$];

  multiplier dut (
    .clk (clk),
    .rst (rst),
    .a   (a),
    .b   (b),
    .c   (c),
    .ovf (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // behavioural reference: full-width multiply, saturate, zero-normalize
  function automatic logic [16:0] ref_mul(input logic [15:0] x, input logic [15:0] y);
    longint unsigned full;
    logic [14:0]     m;
    logic            o;
    logic            s;
    full = longint'(x[14:0]) * longint'(y[14:0]);
    o    = (full > 64'h7FFF);
    m    = o ? 15'h7FFF : full[14:0];
    s    = (x[15] ^ y[15]) && (m != 15'h0);
    return {o, s, m};
  endfunction

  task automatic push(input logic [15:0] x, input logic [15:0] y,
                      input logic [15:0] ec, input logic eo);
    va.push_back(x);
    vb.push_back(y);
    vc.push_back(ec);
    vo.push_back(eo);
  endtask

  // drives one pair per cycle; checks each result two negedges after its drive
  task automatic run_stream(input string tag);
    int n;
    n = va.size();
    for (int i = 0; i < n + 2; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        chk($sformatf("%s%0d_c", tag, i - 2), 32'(c), 32'(vc[i-2]));
        chk($sformatf("%s%0d_ovf", tag, i - 2), 32'(ovf), 32'(vo[i-2]));
      end
      if (i < n) begin
        a = va[i];
        b = vb[i];
      end
    end
    va.delete();
    vb.delete();
    vc.delete();
    vo.delete();
  endtask

  initial begin
    logic [16:0] r;
    logic [15:0] x, y;

    rst = 1'b1;
    a   = 16'h0003;
    b   = 16'h0005;
    repeat (3) @(negedge clk);
    chk("reset_c", 32'(c), 32'h0000);
    chk("reset_ovf", 32'(ovf), 32'h0);
    rst = 1'b0;

    push(16'h0003, 16'h0005, 16'h000F, 1'b0);
    push(16'h8003, 16'h0005, 16'h800F, 1'b0);
    push(16'h8003, 16'h8005, 16'h000F, 1'b0);
    push(16'h8000, 16'h0007, 16'h0000, 1'b0);
    push(16'h8009, 16'h0000, 16'h0000, 1'b0);
    push(16'h8000, 16'h8000, 16'h0000, 1'b0);
    push(16'h00C8, 16'h00C8, 16'h7FFF, 1'b1);
    push(16'h80C8, 16'h00C8, 16'hFFFF, 1'b1);
    push(16'h00B5, 16'h00B5, 16'h7FF9, 1'b0);
    push(16'h80B6, 16'h00B5, 16'hFFFF, 1'b1);
    push(16'hFFFF, 16'hFFFF, 16'h7FFF, 1'b1);
    push(16'h8001, 16'h7FFF, 16'hFFFF, 1'b0);
    run_stream("dir");

    // 100*300 = 30000 fits in 15 bits, so it is 7530h with no overflow
    push(16'h0003, 16'h0005, 16'h000F, 1'b0);
    push(16'h0002, 16'h0007, 16'h000E, 1'b0);
    push(16'h0064, 16'h012C, 16'h7530, 1'b0);
    push(16'h0001, 16'h7FFF, 16'h7FFF, 1'b0);
    push(16'h0000, 16'h0001, 16'h0000, 1'b0);
    run_stream("pipe");

    @(negedge clk);
    a = 16'h0003;
    b = 16'h0005;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_c", 32'(c), 32'h0000);
    chk("rst_mid_ovf", 32'(ovf), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_edge1_c", 32'(c), 32'h0000);
    @(negedge clk);
    chk("rst_edge2_c", 32'(c), 32'h000F);
    chk("rst_edge2_ovf", 32'(ovf), 32'h0);

    for (int i = 0; i < 10000; i++) begin
      x = 16'($urandom);
      y = 16'($urandom);
      x[14:0] = x[14:0] >> $urandom_range(0, 14);
      y[14:0] = y[14:0] >> $urandom_range(0, 14);
      r = ref_mul(x, y);
      push(x, y, r[15:0], r[16]);
    end
    run_stream("rnd");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
